// File: rtl/pe_pkg.sv
// pe_pkg: shared PE-array widths, drain state enum and saturation bounds
package pe_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int PSUM_WIDTH = 32;
  localparam int N_PEs = 16;
  localparam int BIAS_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} drain_state_t;
  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction
  localparam int SAT_HI = sat_hi(DATA_WIDTH);
  localparam int SAT_LO = sat_lo(DATA_WIDTH);
endpackage

// File: rtl/psum_requant.sv
// psum_requant: round/shift/saturate/ReLU of one psum lane; PSUM_ROUND_EN selects round half-up
module psum_requant #(
  parameter int DATA_WIDTH = pe_pkg::DATA_WIDTH,
  parameter int PSUM_WIDTH = pe_pkg::PSUM_WIDTH,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic [PSUM_WIDTH-1:0]  psum,
  input  logic [SHIFT_WIDTH-1:0] qs,
  input  logic                   relu,
  output logic [DATA_WIDTH-1:0]  q
);
  import pe_pkg::*;
  localparam logic signed [PSUM_WIDTH:0] HI = (PSUM_WIDTH+1)'(sat_hi(DATA_WIDTH));
  localparam logic signed [PSUM_WIDTH:0] LO = (PSUM_WIDTH+1)'(sat_lo(DATA_WIDTH));
  logic signed [PSUM_WIDTH:0] ext, sh;
  logic [DATA_WIDTH-1:0] sat;
  always_comb begin
    ext = $signed({psum[PSUM_WIDTH-1], psum});
`ifdef PSUM_ROUND_EN
    ext = qs != '0 ? ext + ((PSUM_WIDTH+1)'(1) <<< (qs - SHIFT_WIDTH'(1))) : ext;
`endif
    sh = ext >>> qs;
    sat = sh > HI ? HI[DATA_WIDTH-1:0] : sh < LO ? LO[DATA_WIDTH-1:0] : sh[DATA_WIDTH-1:0];
    q = relu && sat[DATA_WIDTH-1] ? '0 : sat;
  end
endmodule

// File: rtl/psum_drain.sv
// psum_drain: shifts the PE psum chain out, requantises and packs lanes onto a valid/ready stream
// (rounding mode chosen by PSUM_ROUND_EN inside psum_requant)
module psum_drain #(
  parameter int DATA_WIDTH = pe_pkg::DATA_WIDTH,
  parameter int PSUM_WIDTH = pe_pkg::PSUM_WIDTH,
  parameter int N_PEs = pe_pkg::N_PEs,
  parameter int PACK = 4,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [SHIFT_WIDTH-1:0]     quant_shift,
  input  logic                       if_relu,
  input  logic [PSUM_WIDTH-1:0]      psum_in,
  output logic                       shift,
  output logic                       busy,
  output logic                       done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic                       out_last
);
  import pe_pkg::*;
  localparam int CW = $clog2(N_PEs);
  localparam int LW = $clog2(PACK);
  drain_state_t state, state_nx;
  logic [SHIFT_WIDTH-1:0] qs;
  logic relu, pack_full, pack_last, out_free, lane_end, smp_end, fin;
  logic [CW-1:0] smp_cnt;
  logic [LW-1:0] lane_cnt;
  logic [DATA_WIDTH*PACK-1:0] pack;
  logic [DATA_WIDTH-1:0] q;
  psum_requant #(.DATA_WIDTH(DATA_WIDTH), .PSUM_WIDTH(PSUM_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)) u_rq (
    .psum(psum_in), .qs(qs), .relu(relu), .q(q)
  );
  assign out_free = !out_valid || out_ready;
  assign lane_end = lane_cnt == LW'(PACK - 1);
  assign smp_end = smp_cnt == CW'(N_PEs - 1);
  assign fin = out_valid && out_ready && out_last && !pack_full;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    shift = state == DRAIN && !pack_full;
    state_nx = state == IDLE && start ? DRAIN :
               shift && smp_end ? FLUSH :
               state == FLUSH && fin ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      qs <= '0;
      relu <= 1'b0;
      smp_cnt <= '0;
      lane_cnt <= '0;
      pack <= '0;
      pack_full <= 1'b0;
      pack_last <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == FLUSH && fin;
      if (state == IDLE && start) begin
        qs <= quant_shift;
        relu <= if_relu;
        smp_cnt <= '0;
        lane_cnt <= '0;
        pack_full <= 1'b0;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
      if (shift) begin
        smp_cnt <= smp_cnt + CW'(1);
        lane_cnt <= lane_end ? '0 : lane_cnt + LW'(1);
        pack[lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= q;
        if (lane_end && out_free) begin
          out_data <= {q, pack[DATA_WIDTH*(PACK-1)-1:0]};
          out_valid <= 1'b1;
          out_last <= smp_end;
        end else if (lane_end) begin
          pack_full <= 1'b1;
          pack_last <= smp_end;
        end
      end else if (pack_full && out_free) begin
        out_data <= pack;
        out_valid <= 1'b1;
        out_last <= pack_last;
        pack_full <= 1'b0;
      end
    end
  end
endmodule
